// File: rtl/uart_alu_interface.sv
// Three-byte frame collector (A, B, opcode) feeding an 8-bit ALU; the result is
// handed to the UART transmitter, and the block stays busy until the transmission completes.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_op_error,
    output logic               o_drop
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    state_t             state, state_next;
    logic [NB_DATA-1:0] reg_a, reg_b, tx_data;
    logic [NB_OP-1:0]   reg_op;
    logic               drop;
    logic [NB_DATA:0]   alu_new;
    logic [NB_DATA:0]   alu_held;

    // Returns {valid, result}; undefined opcodes give valid=0 and a zero result.
    function automatic logic [NB_DATA:0] alu(input logic [NB_DATA-1:0] a,
                                             input logic [NB_DATA-1:0] b,
                                             input logic [NB_OP-1:0]   op);
        logic [NB_DATA-1:0] res;
        logic               valid;
        res   = '0;
        valid = 1'b1;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SRA: res = (b >= SHIFT_LIMIT) ? {NB_DATA{a[NB_DATA-1]}}
                                             : NB_DATA'($signed(a) >>> b);
            OP_SRL: res = (b >= SHIFT_LIMIT) ? '0 : (a >> b);
            default: begin
                res   = '0;
                valid = 1'b0;
            end
        endcase
        return {valid, res};
    endfunction

    assign alu_new  = alu(reg_a, reg_b, i_rx_data[NB_OP-1:0]);
    assign alu_held = alu(reg_a, reg_b, reg_op);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= WAIT_A;
            reg_a   <= '0;
            reg_b   <= '0;
            reg_op  <= '0;
            tx_data <= '0;
            drop    <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= i_rx_done_tick && (state == SEND || state == WAIT_TX);
            if (i_rx_done_tick) begin
                case (state)
                    WAIT_A:  reg_a <= i_rx_data;
                    WAIT_B:  reg_b <= i_rx_data;
                    WAIT_OP: begin
                        reg_op  <= i_rx_data[NB_OP-1:0];
                        tx_data <= alu_new[NB_DATA-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (i_rx_done_tick) state_next = WAIT_B;
            WAIT_B:  if (i_rx_done_tick) state_next = WAIT_OP;
            WAIT_OP: if (i_rx_done_tick) state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done_tick) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // The stored opcode is still valid in SEND, so the error flag is decoded from it.
    assign o_tx_data  = tx_data;
    assign o_tx_start = (state == SEND);
    assign o_busy     = (state == SEND) || (state == WAIT_TX);
    assign o_op_error = (state == SEND) && !alu_held[NB_DATA];
    assign o_drop     = drop;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: table of ALU frames plus hand-written
// sequences for drops, tx_done timing and asynchronous reset.
module tb_uart_alu_interface;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_tick;
    logic       tx_tick;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       op_error;
    logic       drop;

    int unsigned n_tests;
    int unsigned n_fail;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_rx_data      (rx_data),
        .i_rx_done_tick (rx_tick),
        .i_tx_done_tick (tx_tick),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy),
        .o_op_error     (op_error),
        .o_drop         (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rx_byte(input logic [7:0] v);
        @(negedge clk);
        rx_data = v;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    // After return we are at the negedge in which SEND is visible.
    task automatic rx_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
    endtask

    task automatic tx_done_pulse();
        tx_tick = 1'b1;
        @(negedge clk);
        tx_tick = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        rx_frame(v.a, v.b, v.op);
        check({tag, " start"},    32'(tx_start), 32'd1);
        check({tag, " data"},     32'(tx_data),  32'(v.res));
        check({tag, " op_error"}, 32'(op_error), 32'(v.err));
        check({tag, " busy"},     32'(busy),     32'd1);
        @(negedge clk);
        check({tag, " start_1cyc"}, 32'(tx_start), 32'd0);
        check({tag, " err_1cyc"},   32'(op_error), 32'd0);
        check({tag, " hold"},       32'(tx_data),  32'(v.res));
        check({tag, " busy_wait"},  32'(busy),     32'd1);
        @(negedge clk);
        tx_done_pulse();
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rx_data = '0;
        rx_tick = 1'b0;
        tx_tick = 1'b0;

        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
        vecs[1]  = '{8'hF0, 8'h20, 8'h22, 8'hD0, 1'b0};
        vecs[2]  = '{8'hFF, 8'h02, 8'h20, 8'h01, 1'b0};
        vecs[3]  = '{8'h80, 8'h03, 8'h03, 8'hF0, 1'b0};
        vecs[4]  = '{8'h80, 8'h03, 8'h02, 8'h10, 1'b0};
        vecs[5]  = '{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0};
        vecs[6]  = '{8'h12, 8'h34, 8'h3F, 8'h00, 1'b1};
        vecs[7]  = '{8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0};
        vecs[8]  = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0};
        vecs[9]  = '{8'hAA, 8'hFF, 8'h26, 8'h55, 1'b0};
        vecs[10] = '{8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0};
        vecs[11] = '{8'h7F, 8'h09, 8'h03, 8'h00, 1'b0};
        vecs[12] = '{8'h80, 8'h08, 8'h02, 8'h00, 1'b0};
        vecs[13] = '{8'h10, 8'h20, 8'hE0, 8'h30, 1'b0};
        vecs[14] = '{8'hC5, 8'h44, 8'h01, 8'h00, 1'b1};

        repeat (2) @(negedge clk);
        check("reset tx_data",  32'(tx_data),  32'd0);
        check("reset start",    32'(tx_start), 32'd0);
        check("reset busy",     32'(busy),     32'd0);
        check("reset op_error", 32'(op_error), 32'd0);
        check("reset drop",     32'(drop),     32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Byte received in WAIT_TX is dropped and does not become operand A.
        rx_frame(8'h05, 8'h03, 8'h20);
        @(negedge clk);
        rx_byte(8'h77);
        check("drop wait_tx",  32'(drop),    32'd1);
        check("drop busy",     32'(busy),    32'd1);
        check("drop hold",     32'(tx_data), 32'h08);
        @(negedge clk);
        check("drop 1cyc",     32'(drop),    32'd0);
        tx_done_pulse();
        run_vec('{8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0}, "after_drop");

        // rx and tx_done both arrive during SEND: tx_done ignored, byte dropped.
        rx_frame(8'h01, 8'h02, 8'h20);
        check("send start", 32'(tx_start), 32'd1);
        rx_data = 8'h99;
        rx_tick = 1'b1;
        tx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        tx_tick = 1'b0;
        check("send txdone ignored", 32'(busy), 32'd1);
        check("send drop",           32'(drop), 32'd1);
        check("send hold",           32'(tx_data), 32'h03);

        // Simultaneous rx and tx_done in WAIT_TX: go idle, byte dropped.
        @(negedge clk);
        rx_data = 8'h66;
        rx_tick = 1'b1;
        tx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        tx_tick = 1'b0;
        check("simul idle", 32'(busy), 32'd0);
        check("simul drop", 32'(drop), 32'd1);
        run_vec('{8'h01, 8'h02, 8'h20, 8'h03, 1'b0}, "after_simul");

        // Asynchronous reset mid-frame clears the held result immediately.
        rx_byte(8'h11);
        rx_byte(8'h22);
        check("pre-reset data", 32'(tx_data), 32'h03);
        #3 rst = 1'b1;
        #1;
        check("async rst data",  32'(tx_data),  32'd0);
        check("async rst busy",  32'(busy),     32'd0);
        check("async rst start", 32'(tx_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{8'h01, 8'h01, 8'h20, 8'h02, 1'b0}, "after_rst");

        // Asynchronous reset during WAIT_TX drops busy immediately.
        rx_frame(8'h09, 8'h01, 8'h22);
        @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst wait_tx busy", 32'(busy),    32'd0);
        check("rst wait_tx data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{8'h09, 8'h01, 8'h22, 8'h08, 1'b0}, "after_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sits directly downstream of the UART receiver and upstream of the UART transmitter in the TP2 top.
- Collects three received bytes in order (operand A, operand B, opcode) and evaluates them with an internal 8-bit ALU.
- Hands the result byte to the transmitter with a one-cycle start pulse, then waits for transmission to finish before accepting the next frame.

Parameters:
- NB_DATA, 8, width of operands, opcode byte and result (equals the UART DBIT).
- NB_OP, 6, number of opcode LSBs decoded; the upper bits of the opcode byte are ignored.

Ports:
- i_clock  in  1  system clock, same clock as the baudrate generator.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only in the cycle i_rx_done_tick=1.
- i_rx_done_tick  in  1  one-cycle pulse from the receiver: byte available.
- i_tx_done_tick  in  1  one-cycle pulse from the transmitter: stop bit finished.
- o_tx_data  out  NB_DATA  result byte to the transmitter; held stable from start pulse until done.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  out  1  high in states SEND and WAIT_TX.
- o_op_error  out  1  one-cycle pulse when the opcode is not in the table.
- o_drop  out  1  one-cycle pulse when a received byte is discarded.

Behaviour:
- Reset (async, active-high):
  - state=WAIT_A.
  - Internal registers A, B and OP are cleared.
  - All outputs are 0: o_tx_data=0, o_tx_start=0, o_busy=0, o_op_error=0, o_drop=0.
  - Reset mid-frame or mid-transmission discards everything; there is no recovery of partial frames.
- FSM states and transitions (all on the rising edge of i_clock):
  - WAIT_A: on i_rx_done_tick, A<=i_rx_data, go to WAIT_B.
  - WAIT_B: on i_rx_done_tick, B<=i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done_tick, OP<=i_rx_data[NB_OP-1:0]; o_tx_data<=ALU(A, B, i_rx_data[NB_OP-1:0]); go to SEND.
  - SEND: lasts exactly 1 cycle with o_tx_start=1; go to WAIT_TX.
  - WAIT_TX: hold o_tx_data; on i_tx_done_tick go to WAIT_A.
- Latency: opcode rx_done_tick at edge N gives o_tx_start high in cycle N+1 only.
- A tx_done_tick arriving in the same cycle as SEND is ignored; only a done pulse seen in WAIT_TX counts.
- Every input except i_clock and i_reset is ignored in SEND.
- Received bytes while busy:
  - An i_rx_done_tick in SEND or WAIT_TX does not change any register.
  - It produces o_drop=1 in the next cycle.
- Simultaneous i_rx_done_tick and i_tx_done_tick in WAIT_TX:
  - Go to WAIT_A.
  - The byte is dropped and o_drop pulses.
- ALU, combinational inside the block, NB_DATA-bit results with carries and borrows discarded (wrap mod 2^NB_DATA):
  - 6'b100000 ADD: A+B.
  - 6'b100010 SUB: A-B.
  - 6'b100100 AND: A&B.
  - 6'b100101 OR: A|B.
  - 6'b100110 XOR: A^B.
  - 6'b100111 NOR: ~(A|B).
  - 6'b000011 SRA: $signed(A)>>>B. The full B is used as the shift amount; B>=8 gives 8'hFF if A[7]=1, else 8'h00.
  - 6'b000010 SRL: A>>B. B>=8 gives 8'h00.
- Undefined opcode:
  - Result is 8'h00 and the result is still transmitted.
  - o_op_error=1 in the same cycle as o_tx_start.
- No timeout exists: the FSM waits indefinitely in WAIT_B, WAIT_OP or WAIT_TX.

Test Plan:
- Reset, then rx bytes 8'h05, 8'h03, 8'h20 -> one o_tx_start pulse, cycle after 3rd rx tick, o_tx_data=8'h08; o_busy=1 until i_tx_done_tick.
- A=8'hF0, B=8'h20, OP=8'h22 (SUB) -> 8'hD0. Then A=8'hFF, B=8'h02, OP=8'h20 -> 8'h01 (wrap).
- A=8'h80, B=8'h03, OP=8'h03 (SRA) -> 8'hF0. Then OP=8'h02 (SRL) -> 8'h10. Then A=8'h80, B=8'h09, SRA -> 8'hFF.
- OP=8'h3F -> o_tx_data=8'h00 and o_op_error high in the same cycle as o_tx_start, one cycle only.
- Byte received during WAIT_TX -> o_drop pulse, A/B unchanged. The next frame 8'h0C, 8'h0A, 8'h24 after tx_done gives 8'h08.
- Assert i_reset after the 2nd byte (async, mid-cycle) -> outputs are 0 immediately. A following full frame 8'h01, 8'h01, 8'h20 gives 8'h02.
